// File: rtl/debounce_edge_detector_pkg.sv
// Shared constants and helpers for the debounce / edge-detect slice.
// DEBOUNCE_SYNC_EN (defined) adds a 2-flop input synchronizer ahead of the debouncer.
package debounce_edge_detector_pkg;

    localparam logic LOW  = 1'b0;
    localparam logic HIGH = 1'b1;
    localparam logic YES  = 1'b1;
    localparam logic NO   = 1'b0;

    // Width that holds 0..cycles inclusive, so the count can never wrap.
    function automatic int cnt_width(input int cycles);
        return (cycles < 1) ? 1 : $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/debounce_edge_detector_if.sv
// Bundle of the debounced-line signals: raw input, filtered level and its edge pulses.
interface debounce_edge_detector_if;

    logic bit_in;
    logic bit_out;
    logic pos_edge;
    logic neg_edge;

    // Handshake-free level/pulse bus: the master drives bit_in and samples the rest;
    // bit_out is a registered level, pos_edge/neg_edge are one-clock pulses.
    modport master (output bit_in, input bit_out, input pos_edge, input neg_edge);
    modport slave  (input bit_in, output bit_out, output pos_edge, output neg_edge);
    modport edge_src (input bit_out, output pos_edge, output neg_edge);

endinterface

// File: rtl/debounce_edge_detector_edge_detector.sv
// Edge detector: remembers the previous debounced level and pulses on each change.
module edge_detector
    import debounce_edge_detector_pkg::*;
#(
    parameter logic RESET_LEVEL = HIGH
) (
    input logic                        clk,
    input logic                        reset,
    debounce_edge_detector_if.edge_src bus
);

    logic prev_q;
    logic prev_d;

    always_comb begin
        prev_d = bus.bit_out;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            prev_q <= RESET_LEVEL;
        end else begin
            prev_q <= prev_d;
        end
    end

    // Both sides are flops that reset to the same level, so no pulse can follow reset.
    assign bus.pos_edge = bus.bit_out & ~prev_q;
    assign bus.neg_edge = ~bus.bit_out & prev_q;

endmodule

// File: rtl/debounce_edge_detector.sv
// Debouncer: bit_out follows bit_in only after CYCLES consecutive mismatching clocks.
// DEBOUNCE_SYNC_EN selects a 2-flop synchronizer in front (latency CYCLES+2, else CYCLES).
module debounce_edge_detector
    import debounce_edge_detector_pkg::*;
#(
    parameter int   CYCLES      = 255,
    parameter logic RESET_LEVEL = HIGH
) (
    input  logic clk,
    input  logic reset,
    input  logic bit_in,
    output logic bit_out,
    output logic pos_edge,
    output logic neg_edge
);

    localparam int            CW   = cnt_width(CYCLES);
    localparam logic [CW-1:0] LAST = CW'(CYCLES - 1);

    debounce_edge_detector_if u_bus ();

    assign u_bus.bit_in = bit_in;

    logic s_cmp;

`ifdef DEBOUNCE_SYNC_EN
    logic sync0_q;
    logic sync0_d;
    logic sync1_q;
    logic sync1_d;

    always_comb begin
        sync0_d = u_bus.bit_in;
        sync1_d = sync0_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync0_q <= RESET_LEVEL;
            sync1_q <= RESET_LEVEL;
        end else begin
            sync0_q <= sync0_d;
            sync1_q <= sync1_d;
        end
    end

    assign s_cmp = sync1_q;
`else
    assign s_cmp = u_bus.bit_in;
`endif

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          bit_out_q;
    logic          bit_out_d;
    logic          mismatch;

    assign mismatch = (s_cmp != bit_out_q) ? YES : NO;

    // A match at any point throws away the partial count; the CYCLES-th mismatch commits.
    always_comb begin
        cnt_d     = '0;
        bit_out_d = bit_out_q;
        if (mismatch == YES) begin
            if (cnt_q == LAST) begin
                bit_out_d = s_cmp;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q     <= '0;
            bit_out_q <= RESET_LEVEL;
        end else begin
            cnt_q     <= cnt_d;
            bit_out_q <= bit_out_d;
        end
    end

    assign u_bus.bit_out = bit_out_q;

    edge_detector #(
        .RESET_LEVEL(RESET_LEVEL)
    ) u_edge (
        .clk  (clk),
        .reset(reset),
        .bus  (u_bus.edge_src)
    );

    assign bit_out  = bit_out_q;
    assign pos_edge = u_bus.pos_edge;
    assign neg_edge = u_bus.neg_edge;

endmodule

// File: tb/tb_debounce_edge_detector.sv
// Bench for debounce_edge_detector: directed scenarios plus random bouncing on two instances.
// Model: the output flips once the effective input has disagreed with it for CYCLES clocks.
module tb_debounce_edge_detector;

`ifdef DEBOUNCE_SYNC_EN
    localparam int SYNC_LAT = 2;
`else
    localparam int SYNC_LAT = 0;
`endif
    localparam int   CYC_A = 4;
    localparam int   CYC_B = 255;
    localparam logic RL    = 1'b1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a;
    logic rst_b;

    debounce_edge_detector_if bus_a ();
    debounce_edge_detector_if bus_b ();

    debounce_edge_detector #(.CYCLES(CYC_A), .RESET_LEVEL(RL)) dut_a (
        .clk(clk), .reset(rst_a), .bit_in(bus_a.bit_in), .bit_out(bus_a.bit_out),
        .pos_edge(bus_a.pos_edge), .neg_edge(bus_a.neg_edge)
    );

    debounce_edge_detector #(.CYCLES(CYC_B), .RESET_LEVEL(RL)) dut_b (
        .clk(clk), .reset(rst_b), .bit_in(bus_b.bit_in), .bit_out(bus_b.bit_out),
        .pos_edge(bus_b.pos_edge), .neg_edge(bus_b.neg_edge)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    // Model state: time stamp of the last clock the output and effective input agreed.
    int         t = 0;
    int         anchor [2];
    logic       m_out  [2];
    logic       m_prev [2];
    logic [1:0] m_pipe [2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge(input int i, input int cyc, input logic r, input logic b);
        logic eff;
        if (r) begin
            m_out[i]  = RL;
            m_prev[i] = RL;
            m_pipe[i] = {RL, RL};
            anchor[i] = t;
        end else begin
            eff       = (SYNC_LAT == 2) ? m_pipe[i][1] : b;
            m_pipe[i] = {m_pipe[i][0], b};
            m_prev[i] = m_out[i];
            if (eff == m_out[i]) begin
                anchor[i] = t;
            end else if (t - anchor[i] >= cyc) begin
                m_out[i]  = eff;
                anchor[i] = t;
            end
        end
    endtask

    task automatic compare_all();
        chk("out_a", 32'(bus_a.bit_out), 32'(m_out[0]));
        chk("pos_a", 32'(bus_a.pos_edge), 32'(m_out[0] & ~m_prev[0]));
        chk("neg_a", 32'(bus_a.neg_edge), 32'(~m_out[0] & m_prev[0]));
        chk("both_a", 32'(bus_a.pos_edge & bus_a.neg_edge), 32'(0));
        chk("cnt_bound_a", 32'(dut_a.cnt_q <= CYC_A), 32'(1));
        chk("out_b", 32'(bus_b.bit_out), 32'(m_out[1]));
        chk("pos_b", 32'(bus_b.pos_edge), 32'(m_out[1] & ~m_prev[1]));
        chk("neg_b", 32'(bus_b.neg_edge), 32'(~m_out[1] & m_prev[1]));
        chk("both_b", 32'(bus_b.pos_edge & bus_b.neg_edge), 32'(0));
        chk("cnt_bound_b", 32'(dut_b.cnt_q <= CYC_B), 32'(1));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge(0, CYC_A, rst_a, bus_a.bit_in);
        model_edge(1, CYC_B, rst_b, bus_b.bit_in);
        t++;
        #1;
        compare_all();
    endtask

    initial begin
        int n;
        int hold_a;
        int hold_b;

        for (int i = 0; i < 2; i++) begin
            anchor[i] = 0;
            m_out[i]  = RL;
            m_prev[i] = RL;
            m_pipe[i] = {RL, RL};
        end

        // Reset held for 3 clocks with the line low.
        rst_a = 1'b1;
        rst_b = 1'b1;
        bus_a.bit_in = 1'b0;
        bus_b.bit_in = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("rst_out_a", 32'(bus_a.bit_out), 32'(1));
            chk("rst_pos_a", 32'(bus_a.pos_edge), 32'(0));
            chk("rst_neg_a", 32'(bus_a.neg_edge), 32'(0));
            chk("rst_out_b", 32'(bus_b.bit_out), 32'(1));
        end
        rst_a = 1'b0;
        rst_b = 1'b0;
        bus_a.bit_in = 1'b1;
        bus_b.bit_in = 1'b1;
        step();
        chk("post_rst_pos_a", 32'(bus_a.pos_edge), 32'(0));
        chk("post_rst_neg_a", 32'(bus_a.neg_edge), 32'(0));
        repeat (6) step();

        // Glitch: three low clocks are one short of CYCLES=4.
        bus_a.bit_in = 1'b0;
        repeat (3) step();
        bus_a.bit_in = 1'b1;
        for (int k = 0; k < 10; k++) begin
            step();
            chk("glitch_out", 32'(bus_a.bit_out), 32'(1));
            chk("glitch_pos", 32'(bus_a.pos_edge), 32'(0));
            chk("glitch_neg", 32'(bus_a.neg_edge), 32'(0));
        end

        // Clean fall.
        bus_a.bit_in = 1'b0;
        n = 0;
        do begin
            step();
            n++;
        end while (bus_a.bit_out !== 1'b0 && n < 20);
        chk("fall_latency", 32'(n), 32'(CYC_A + SYNC_LAT));
        chk("fall_neg", 32'(bus_a.neg_edge), 32'(1));
        chk("fall_pos", 32'(bus_a.pos_edge), 32'(0));
        step();
        chk("fall_neg_once", 32'(bus_a.neg_edge), 32'(0));
        chk("fall_hold", 32'(bus_a.bit_out), 32'(0));

        // Clean rise.
        bus_a.bit_in = 1'b1;
        n = 0;
        do begin
            step();
            n++;
        end while (bus_a.bit_out !== 1'b1 && n < 20);
        chk("rise_latency", 32'(n), 32'(CYC_A + SYNC_LAT));
        chk("rise_pos", 32'(bus_a.pos_edge), 32'(1));
        chk("rise_neg", 32'(bus_a.neg_edge), 32'(0));
        step();
        chk("rise_pos_once", 32'(bus_a.pos_edge), 32'(0));
        chk("rise_hold", 32'(bus_a.bit_out), 32'(1));

        // Mid-count reset on the CYCLES=255 instance.
        bus_b.bit_in = 1'b0;
        repeat (100) step();
        chk("mid_cnt_pre", 32'(dut_b.cnt_q), 32'(100 - SYNC_LAT));
        rst_b = 1'b1;
        step();
        chk("mid_cnt", 32'(dut_b.cnt_q), 32'(0));
        chk("mid_out", 32'(bus_b.bit_out), 32'(1));
        chk("mid_neg", 32'(bus_b.neg_edge), 32'(0));
        rst_b = 1'b0;
        n = 0;
        do begin
            step();
            n++;
        end while (bus_b.bit_out !== 1'b0 && n < 400);
        chk("mid_fall_latency", 32'(n), 32'(CYC_B + SYNC_LAT));
        chk("mid_fall_neg", 32'(bus_b.neg_edge), 32'(1));

        // Random bouncing: short holds on A, a mix of glitches and long holds on B.
        hold_a = 0;
        hold_b = 0;
        for (int k = 0; k < 2500; k++) begin
            if (hold_a == 0) begin
                bus_a.bit_in = 1'($urandom_range(0, 1));
                hold_a       = int'($urandom_range(1, 8));
                rst_a        = ($urandom_range(0, 49) == 0);
            end else begin
                hold_a--;
                rst_a = 1'b0;
            end
            if (hold_b == 0) begin
                bus_b.bit_in = 1'($urandom_range(0, 1));
                hold_b       = ($urandom_range(0, 1) == 0) ? int'($urandom_range(1, 5))
                                                           : int'($urandom_range(200, 300));
                rst_b        = ($urandom_range(0, 199) == 0);
            end else begin
                hold_b--;
                rst_b = 1'b0;
            end
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
